mem_noc_sram_bridge: RTL and testbench

- Destination-side consumer of the memory request NoC. It sits directly downstream of the dest_* port of cdc_mem_noc.
- Accepts valid/ready memory requests in the slow (destination) clock domain and issues them to a single-port synchronous SRAM with 1-cycle read latency.
- Returns one response per request through a credit-limited response FIFO.
- Out-of-range or misaligned requests never touch the SRAM and complete with an error response.

---
 rtl/mem_noc_sram_bridge.sv | 158 +++++++++++++++
 tb/tb_mem_noc_sram_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_noc_sram_bridge.sv
// Small synchronous FIFO holding completed responses in order.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: none internally; the caller must never push when full.
module mem_noc_sram_bridge_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             wdat_i,
  output logic [W-1:0]             rdat_o,
  output logic [$clog2(DEPTH):0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_i) wptr_d = wptr_q + AW'(1);
    if (pop_i)  rptr_d = rptr_q + AW'(1);
    if (push_i && !pop_i)      count_d = count_q + CW'(1);
    else if (!push_i && pop_i) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdat_i;
  end

  assign rdat_o  = mem_q[rptr_q];
  assign count_o = count_q;
endmodule

// Bridges NoC memory requests onto a 1-cycle-latency single-port SRAM.
// Latency: response valid two cycles after accept when the response FIFO is empty.
// Backpressure: req_ready is a credit check on buffered plus in-flight responses.
module mem_noc_sram_bridge #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                SRAM_AW    = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                RESP_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [ADDR_W-1:0]  req_addr,
  input  logic               req_wen,
  input  logic [DATA_W-1:0]  req_wdata,
  input  logic [3:0]         req_wmask,
  output logic               sram_ce,
  output logic               sram_we,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [DATA_W-1:0]  sram_wdata,
  output logic [3:0]         sram_wmask,
  input  logic [DATA_W-1:0]  sram_rdata,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_rdata,
  output logic               resp_err,
  output logic               resp_wen
);
  localparam int CW = $clog2(RESP_DEPTH) + 1;
  localparam int RW = DATA_W + 2;

  logic          accept;
  logic          hit;
  logic          inflight_q, inflight_d;
  logic          inf_hit_q, inf_hit_d;
  logic          inf_wen_q, inf_wen_d;
  logic [CW-1:0] fifo_cnt;
  logic [CW:0]   credits_used;
  logic [RW-1:0] push_dat;
  logic [RW-1:0] head_dat;
  logic [RW-1:0] resp_dat;
  logic          pop;

  assign credits_used = {1'b0, fifo_cnt} + (CW+1)'(inflight_q);
  assign req_ready    = credits_used < (CW+1)'(RESP_DEPTH);
  assign accept       = req_valid && req_ready;

  assign hit = (req_addr[ADDR_W-1:SRAM_AW+2] == BASE_ADDR[ADDR_W-1:SRAM_AW+2]) &&
               (req_addr[1:0] == 2'b00);

  // SRAM strobes are combinational from the request in its accept cycle.
  assign sram_ce    = accept && hit;
  assign sram_we    = sram_ce && req_wen;
  assign sram_addr  = req_addr[SRAM_AW+1:2];
  assign sram_wdata = req_wdata;
  assign sram_wmask = sram_ce ? req_wmask : 4'b0000;

  always_comb begin
    inflight_d = accept;
    inf_hit_d  = hit;
    inf_wen_d  = req_wen;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inflight_q <= 1'b0;
      inf_hit_q  <= 1'b0;
      inf_wen_q  <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
      inf_hit_q  <= inf_hit_d;
      inf_wen_q  <= inf_wen_d;
    end
  end

  // Only a read that reached the SRAM carries data; misses report err.
  assign push_dat = {(inf_hit_q && !inf_wen_q) ? sram_rdata : '0, !inf_hit_q, inf_wen_q};

  assign pop = resp_valid && resp_ready;

  mem_noc_sram_bridge_fifo #(
    .W     (RW),
    .DEPTH (RESP_DEPTH)
  ) u_resp_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (inflight_q),
    .pop_i   (pop),
    .wdat_i  (push_dat),
    .rdat_o  (head_dat),
    .count_o (fifo_cnt)
  );

  assign resp_valid = (fifo_cnt != '0);
  assign resp_dat   = resp_valid ? head_dat : '0;
  assign resp_rdata = resp_dat[RW-1:2];
  assign resp_err   = resp_dat[1];
  assign resp_wen   = resp_dat[0];

  a_no_push_when_full: assert property (@(posedge clk) disable iff (!rstn)
    !(inflight_q && (fifo_cnt == CW'(RESP_DEPTH))));
endmodule

// File: tb/tb_mem_noc_sram_bridge.sv
// Randomized and directed bench for mem_noc_sram_bridge with an SRAM device and response model.
module tb_mem_noc_sram_bridge;
  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          WORDS = 1024;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req_valid, req_ready, req_wen;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_wmask;
  logic        sram_ce, sram_we;
  logic [9:0]  sram_addr;
  logic [31:0] sram_wdata, sram_rdata;
  logic [3:0]  sram_wmask;
  logic        resp_valid, resp_ready, resp_err, resp_wen;
  logic [31:0] resp_rdata;

  mem_noc_sram_bridge dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wen(req_wen), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_wen(resp_wen)
  );

  always #5 clk = ~clk;

  // SRAM device: masked write, registered read, contents survive reset.
  logic [31:0] sram_mem [WORDS];
  initial begin
    for (int i = 0; i < WORDS; i++) sram_mem[i] = 32'h0;
    sram_rdata = 32'h0;
  end
  always @(posedge clk) begin
    if (sram_ce) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) sram_mem[sram_addr][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= sram_mem[sram_addr];
      end
    end
  end

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        wen;
    int          cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [WORDS];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_acc = 0;
  int          n_pop = 0;
  logic        last_acc = 1'b0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic in_range(input logic [31:0] a);
    logic [63:0] a64;
    a64 = {32'h0, a};
    return (a64 >= {32'h0, BASE}) && (a64 < {32'h0, BASE} + 64'(WORDS * 4)) && (a[1:0] == 2'b00);
  endfunction

  // One clock: sample and check mid-cycle, update the model, return just after the edge.
  task automatic tick();
    logic  acc, pop, hit, exp_vld;
    exp_t  e;
    int    idx;
    @(negedge clk);
    cyc++;
    chk1("req_ready", req_ready, exp_q.size() < DEPTH);
    exp_vld = (exp_q.size() != 0) && (exp_q[0].cyc + 2 <= cyc);
    chk1("resp_valid", resp_valid, exp_vld);
    acc = req_valid && req_ready;
    hit = in_range(req_addr);
    chk1("sram_ce", sram_ce, acc && hit);
    if (acc && hit) begin
      chk32("sram_addr", 32'(sram_addr), (req_addr - BASE) >> 2);
      chk1("sram_we", sram_we, req_wen);
      if (req_wen) begin
        chk32("sram_wdata", sram_wdata, req_wdata);
        chk32("sram_wmask", 32'(sram_wmask), 32'(req_wmask));
      end
    end
    pop = resp_valid && resp_ready;
    if (pop && exp_q.size() != 0) begin
      chk32("resp_rdata", resp_rdata, exp_q[0].rdata);
      chk1("resp_err", resp_err, exp_q[0].err);
      chk1("resp_wen", resp_wen, exp_q[0].wen);
      last_rdata = resp_rdata;
      void'(exp_q.pop_front());
      n_pop++;
    end
    if (acc) begin
      e.cyc = cyc;
      e.wen = req_wen;
      e.err = !hit;
      e.rdata = 32'h0;
      if (hit) begin
        idx = int'((req_addr - BASE) >> 2);
        if (req_wen) begin
          for (int b = 0; b < 4; b++)
            if (req_wmask[b]) model_mem[idx][8*b +: 8] = req_wdata[8*b +: 8];
        end else begin
          e.rdata = model_mem[idx];
        end
      end
      exp_q.push_back(e);
      n_acc++;
    end
    last_acc = acc;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] m);
    int k;
    k = 0;
    req_valid = 1'b1; req_addr = a; req_wen = w; req_wdata = d; req_wmask = m;
    last_acc = 1'b0;
    while (!last_acc && k < 64) begin
      tick();
      k++;
    end
    chk1("send_accepted", last_acc, 1'b1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    req_valid = 1'b0;
    resp_ready = 1'b1;
    while (exp_q.size() != 0 && k < 100) begin
      tick();
      k++;
    end
    chk32("drain_outstanding", 32'(exp_q.size()), 32'h0);
  endtask

  function automatic logic [31:0] rnd_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r == 0) return 32'h0000_1000 + 32'($urandom_range(0, 255) << 2);
    if (r == 1) return 32'h40 + 32'($urandom_range(0, 15) << 2) + 32'($urandom_range(1, 3));
    return 32'h40 + 32'($urandom_range(0, 15) << 2);
  endfunction

  task automatic rnd_req();
    req_addr  = rnd_addr();
    req_wen   = 1'($urandom_range(0, 1));
    req_wdata = $urandom;
    req_wmask = 4'($urandom_range(0, 15));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base_acc, base_pop;
    for (int i = 0; i < WORDS; i++) model_mem[i] = 32'h0;
    rstn = 1'b0; req_valid = 1'b0; req_addr = 32'h0; req_wen = 1'b0;
    req_wdata = 32'h0; req_wmask = 4'h0; resp_ready = 1'b1;
    #2;
    chk1("rst_resp_valid", resp_valid, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_sram_ce", sram_ce, 1'b0);
    chk32("rst_resp_rdata", resp_rdata, 32'h0);
    chk1("rst_resp_err", resp_err, 1'b0);
    chk1("rst_resp_wen", resp_wen, 1'b0);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Full write then read back; second word gets a partial overwrite.
    send(32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF);
    send(32'h10, 1'b0, 32'h0, 4'h0);
    drain();
    chk32("read_back_full", last_rdata, 32'hDEAD_BEEF);
    send(32'h14, 1'b1, 32'hDEAD_BEEF, 4'hF);
    send(32'h14, 1'b1, 32'h1234_5678, 4'h3);
    send(32'h14, 1'b0, 32'h0, 4'h0);
    drain();
    chk32("read_back_partial", last_rdata, 32'hDEAD_5678);

    // Out-of-range and misaligned accesses.
    send(32'h0000_1000, 1'b0, 32'h0, 4'h0);
    send(32'h11, 1'b0, 32'h0, 4'h0);
    send(32'h0000_2004, 1'b1, 32'hFFFF_FFFF, 4'hF);
    drain();

    // Credit exhaustion with the consumer stalled.
    base_acc = n_acc;
    base_pop = n_pop;
    resp_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send(32'(i * 4), 1'b0, 32'h0, 4'h0);
    req_valid = 1'b1; req_addr = 32'h14; req_wen = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk32("accepted_while_stalled", 32'(n_acc - base_acc), 32'd4);
    resp_ready = 1'b1;
    for (int i = 5; i <= 15; i++) send(32'(i * 4), 1'b0, 32'h0, 4'h0);
    drain();
    chk32("stall_total_accepted", 32'(n_acc - base_acc), 32'd15);
    chk32("stall_total_popped", 32'(n_pop - base_pop), 32'd15);

    // Consumer toggling every cycle under continuous requests.
    resp_ready = 1'b0;
    req_valid = 1'b1;
    rnd_req();
    for (int i = 0; i < 120; i++) begin
      if (last_acc) rnd_req();
      resp_ready = !resp_ready;
      tick();
    end
    drain();

    // Fully random traffic.
    last_acc = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!req_valid || last_acc) begin
        req_valid = ($urandom_range(0, 3) != 0);
        rnd_req();
      end
      resp_ready = 1'($urandom_range(0, 1));
      tick();
    end
    drain();

    // Reset with three responses buffered and one request in flight.
    resp_ready = 1'b0;
    send(32'h44, 1'b0, 32'h0, 4'h0);
    send(32'h48, 1'b0, 32'h0, 4'h0);
    send(32'h4C, 1'b0, 32'h0, 4'h0);
    send(32'h20, 1'b1, 32'hCAFE_F00D, 4'hF);
    chk1("pre_reset_resp_valid", resp_valid, 1'b1);
    rstn = 1'b0;
    #1;
    chk1("mid_rst_resp_valid", resp_valid, 1'b0);
    chk1("mid_rst_req_ready", req_ready, 1'b1);
    chk32("mid_rst_resp_rdata", resp_rdata, 32'h0);
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    send(32'h20, 1'b0, 32'h0, 4'h0);
    drain();
    chk32("post_reset_inflight_write", last_rdata, 32'hCAFE_F00D);
    send(32'h10, 1'b0, 32'h0, 4'h0);
    drain();
    chk32("post_reset_read_0x10", last_rdata, 32'hDEAD_BEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
